// File: rtl/kbd_matrix_mapper_if.sv
// PS/2 byte-stream input and CPU key-matrix scan port of kbd_matrix_mapper.
// The master side drives the PS/2 strobes and row selects; the mapper is the slave.
interface kbd_matrix_mapper_if #(
  parameter int ROWS = 14,
  parameter int COLS = 7
);
  logic [7:0]      ps2_byte;
  logic            ps2_valid;
  logic            ps2_error;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_out;
  logic            any_key;
  logic            reset_key;

  modport master (
    output ps2_byte, ps2_valid, ps2_error, row_sel,
    input  col_out, any_key, reset_key
  );

  modport slave (
    input  ps2_byte, ps2_valid, ps2_error, row_sel,
    output col_out, any_key, reset_key
  );
endinterface

// File: rtl/kbd_matrix_mapper.sv
// PS/2 set-2 scan codes -> Laser 500 style key matrix, scanned by active-low row selects.
// Optional macro KBD_RESET_KEY_EN routes F12 (0x07) to reset_key instead of leaving it unmapped.
module kbd_matrix_mapper #(
  parameter int ROWS             = 14,
  parameter int COLS             = 7,
  parameter bit RELEASE_ON_ERROR = 1'b1
) (
  input logic                clk,
  input logic                reset,
  kbd_matrix_mapper_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] EXT     = 3'd1;
  localparam logic [2:0] REL     = 3'd2;
  localparam logic [2:0] EXT_REL = 3'd3;
  localparam logic [2:0] PAUSE   = 3'd4;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_REL   = 8'hF0;
  localparam logic [7:0] CODE_PAUSE = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } map_entry_t;

  function automatic map_entry_t at(input int r, input int c);
    map_entry_t e;
    e.hit = 1'b1;
    e.row = 4'(r);
    e.col = 3'(c);
    return e;
  endfunction

  // Index is {extended, code}; bit 8 set means the code followed an E0 prefix.
  function automatic map_entry_t lookup(input logic ext, input logic [7:0] code);
    map_entry_t e;
    case ({ext, code})
      9'h012: e = at(0, 6);   // left shift
      9'h01A: e = at(0, 5);   // Z
      9'h022: e = at(0, 4);   // X
      9'h021: e = at(0, 3);   // C
      9'h02A: e = at(0, 2);   // V
      9'h032: e = at(0, 1);   // B
      9'h031: e = at(0, 0);   // N
      9'h01C: e = at(1, 5);   // A
      9'h01B: e = at(1, 4);   // S
      9'h023: e = at(1, 3);   // D
      9'h02B: e = at(1, 2);   // F
      9'h034: e = at(1, 1);   // G
      9'h033: e = at(1, 0);   // H
      9'h015: e = at(2, 5);   // Q
      9'h01D: e = at(2, 4);   // W
      9'h024: e = at(2, 3);   // E
      9'h02D: e = at(2, 2);   // R
      9'h02C: e = at(2, 1);   // T
      9'h035: e = at(2, 0);   // Y
      9'h016: e = at(3, 5);   // 1
      9'h01E: e = at(3, 4);   // 2
      9'h026: e = at(3, 3);   // 3
      9'h025: e = at(3, 2);   // 4
      9'h02E: e = at(3, 1);   // 5
      9'h036: e = at(3, 0);   // 6
      9'h066: e = at(6, 5);   // backspace
      9'h05A: e = at(6, 6);   // return
      9'h029: e = at(7, 4);   // space
      9'h076: e = at(7, 6);   // escape
      9'h00D: e = at(12, 0);  // tab
      9'h175: e = at(11, 3);  // cursor up
      9'h16B: e = at(11, 2);  // cursor left
      9'h174: e = at(11, 1);  // cursor right
      9'h172: e = at(11, 0);  // cursor down
      9'h171: e = at(13, 6);  // delete
      default: e = '0;
    endcase
    return e;
  endfunction

  logic [2:0]                 state;
  logic [2:0]                 pause_cnt;
  logic [ROWS-1:0][COLS-1:0]  key;
  logic [COLS-1:0]            col_q;
  logic                       any_q;

  logic                       is_ext;
  logic                       is_rel;
  logic                       final_byte;
  map_entry_t                 entry;
  logic [ROWS-1:0][COLS-1:0]  hit_mask;
  logic [COLS-1:0]            col_next;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise a path that skips it infers a latch.
  always_comb begin
    is_ext     = (state == EXT) || (state == EXT_REL);
    is_rel     = (state == REL) || (state == EXT_REL);
    final_byte = bus.ps2_valid && !bus.ps2_error && (state != PAUSE) &&
                 (bus.ps2_byte != CODE_EXT) && (bus.ps2_byte != CODE_REL) &&
                 (bus.ps2_byte != CODE_PAUSE);
    entry      = lookup(is_ext, bus.ps2_byte);
    // Entries outside the configured matrix never match any cell and drop out here.
    hit_mask   = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        hit_mask[r][c] = final_byte && entry.hit &&
                         (entry.row == 4'(r)) && (entry.col == 3'(c));
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pause_cnt <= '0;
    end else if (bus.ps2_error) begin
      state     <= IDLE;
      pause_cnt <= '0;
    end else if (bus.ps2_valid) begin
      if (state == PAUSE) begin
        pause_cnt <= pause_cnt - 3'd1;
        if (pause_cnt <= 3'd1) state <= IDLE;
      end else begin
        case (bus.ps2_byte)
          CODE_EXT:   state <= is_rel ? EXT_REL : EXT;
          CODE_REL:   state <= is_ext ? EXT_REL : REL;
          CODE_PAUSE: begin
            state     <= PAUSE;
            pause_cnt <= PAUSE_SKIP;
          end
          default:    state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: the key array is a handful of flops, not a RAM, so it is reset like
  // any other register; a real memory macro would not get a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      key <= '0;
    end else if (bus.ps2_error) begin
      if (RELEASE_ON_ERROR) key <= '0;
    end else if (is_rel) begin
      key <= key & ~hit_mask;
    end else begin
      key <= key | hit_mask;
    end
  end

`ifdef KBD_RESET_KEY_EN
  logic reset_key_q;
  logic is_reset_code;

  assign is_reset_code = final_byte && !is_ext && (bus.ps2_byte == 8'h07);

  always_ff @(posedge clk) begin
    if (reset) begin
      reset_key_q <= 1'b0;
    end else if (bus.ps2_error) begin
      if (RELEASE_ON_ERROR) reset_key_q <= 1'b0;
    end else if (is_reset_code) begin
      reset_key_q <= !is_rel;
    end
  end

  assign bus.reset_key = reset_key_q;
`else
  assign bus.reset_key = 1'b0;
`endif

  // Selected rows pull their pressed columns low: a wired-AND, ghosting included.
  always_comb begin
    col_next = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (!bus.row_sel[r]) col_next = col_next & ~key[r];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '1;
      any_q <= 1'b0;
    end else begin
      col_q <= col_next;
      any_q <= |key;
    end
  end

  assign bus.col_out = col_q;
  assign bus.any_key = any_q;

endmodule
